// File: rtl/regfile_sb.sv
// Two-read/one-write register file with a per-register pending scoreboard and a clear sweep.
// Define REGFILE_BYPASS_EN to forward a same-cycle write onto the read ports.
module regfile_sb #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 3,
   parameter bit          ZERO_REG = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              pend1,
   output logic              pend2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_done
);

   localparam int unsigned       DEPTH  = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] PENULT = ADDR_W'(DEPTH - 2);

   typedef enum logic {StIdle, StClear} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              busy_q;
   logic              clr_done_q;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  pend_q;
   logic [DEPTH-1:0]  pend_d;

   logic wr_ok;
   logic rsv_ok;

   assign wr_ok  = wr_en  && !busy_q && !(ZERO_REG && (wr_addr  == '0));
   assign rsv_ok = rsv_en && !busy_q && !(ZERO_REG && (rsv_addr == '0));

   // Reserve is applied after the write so it wins on a shared address.
   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      if (busy_q) begin
         regs_d[cnt_q] = '0;
         pend_d[cnt_q] = 1'b0;
      end else begin
         if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
            pend_d[wr_addr] = 1'b0;
         end
         if (rsv_ok) begin
            pend_d[rsv_addr] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         pend_q <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
      end
   end

   // clr_done is raised one edge early so it lines up with the last busy cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               clr_done_q <= 1'b0;
               if (clr_req) begin
                  state_q <= StClear;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            StClear: begin
               cnt_q      <= cnt_q + 1'b1;
               clr_done_q <= (cnt_q == PENULT);
               if (cnt_q == LAST) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q    <= StIdle;
               busy_q     <= 1'b0;
               clr_done_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      rd_data1 = regs_q[rd_addr1];
      pend1    = pend_q[rd_addr1];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wr_addr == rd_addr1)) begin
         rd_data1 = wr_data;
         pend1    = rsv_en && (rsv_addr == wr_addr);
      end
`endif
      if (ZERO_REG && (rd_addr1 == '0)) begin
         rd_data1 = '0;
         pend1    = 1'b0;
      end
   end

   always_comb begin
      rd_data2 = regs_q[rd_addr2];
      pend2    = pend_q[rd_addr2];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wr_addr == rd_addr2)) begin
         rd_data2 = wr_data;
         pend2    = rsv_en && (rsv_addr == wr_addr);
      end
`endif
      if (ZERO_REG && (rd_addr2 == '0)) begin
         rd_data2 = '0;
         pend2    = 1'b0;
      end
   end

   assign busy     = busy_q;
   assign clr_done = clr_done_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a default instance plus a ZERO_REG=1 instance on shared inputs.
`timescale 1ns/1ps
module tb_regfile_sb;

   localparam int AW    = 3;
   localparam int DW    = 16;
   localparam int DEPTH = 8;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, rsv_addr;
   logic [DW-1:0] wr_data, rd_data1, rd_data2, z_rd_data1, z_rd_data2;
   logic          pend1, pend2, z_pend1, z_pend2;
   logic          wr_en, rsv_en, clr_req, busy, clr_done, z_busy, z_clr_done;

   typedef struct {
      string         tag;
      logic [DW-1:0] d1;
      logic          p1;
      logic [DW-1:0] d2;
      logic          p2;
   } rd_exp_t;

   typedef struct {
      string tag;
      logic  b;
      logic  c;
   } ctl_exp_t;

   rd_exp_t  sb[$];
   ctl_exp_t sbc[$];
   int       vectors = 0;
   int       errors  = 0;
   logic [DW-1:0] m_regs [DEPTH];
   logic          m_pend [DEPTH];

   always #5 clk = ~clk;

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
      .pend1(pend1), .pend2(pend2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
   );

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) u_dut_z (
      .clk(clk), .reset_n(reset_n),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(z_rd_data1), .rd_data2(z_rd_data2),
      .pend1(z_pend1), .pend2(z_pend2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .clr_req(clr_req), .busy(z_busy), .clr_done(z_clr_done)
   );

   task automatic test_reset();
      rd_exp_t  e;
      ctl_exp_t c;
      #2 reset_n = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         rd_addr1 = AW'(i);
         rd_addr2 = AW'(DEPTH - 1 - i);
         e.tag = $sformatf("reset_read_r%0d", i);
         e.d1 = '0; e.p1 = 1'b0; e.d2 = '0; e.p2 = 1'b0;
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         vectors++;
         if (rd_data1 !== e.d1 || pend1 !== e.p1 || rd_data2 !== e.d2 || pend2 !== e.p2) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.tag, rd_data1, pend1,
                     rd_data2, pend2, e.d1, e.p1, e.d2, e.p2);
         end
      end
      c.tag = "reset_ctl"; c.b = 1'b0; c.c = 1'b0;
      sbc.push_back(c);
      c = sbc.pop_front();
      vectors++;
      if (busy !== c.b || clr_done !== c.c) begin
         errors++;
         $display("FAIL %s: busy=%b clr_done=%b want %b %b", c.tag, busy, clr_done, c.b, c.c);
      end
      reset_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   task automatic test_write();
      rd_exp_t e;
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF;
      @(posedge clk); #1;
      wr_en = 1'b0;
      m_regs[5] = 16'hBEEF; m_pend[5] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         rd_addr1 = AW'(i);
         rd_addr2 = AW'(i);
         e.tag = $sformatf("write_read_r%0d", i);
         e.d1 = m_regs[i]; e.p1 = m_pend[i]; e.d2 = m_regs[i]; e.p2 = m_pend[i];
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         vectors++;
         if (rd_data1 !== e.d1 || pend1 !== e.p1 || rd_data2 !== e.d2 || pend2 !== e.p2) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.tag, rd_data1, pend1,
                     rd_data2, pend2, e.d1, e.p1, e.d2, e.p2);
         end
      end
   endtask

   task automatic test_scoreboard();
      rd_exp_t e;
      for (int step = 0; step < 3; step++) begin
         @(posedge clk); #1;
         wr_addr = 3'd3; rsv_addr = 3'd3;
         wr_en   = (step != 0);
         rsv_en  = (step != 1);
         wr_data = (step == 1) ? 16'h1234 : 16'h0055;
         @(posedge clk); #1;
         if (wr_en) m_regs[3] = wr_data;
         m_pend[3] = rsv_en;
         wr_en = 1'b0; rsv_en = 1'b0;
         rd_addr1 = 3'd3; rd_addr2 = 3'd5;
         e.tag = $sformatf("scoreboard_step%0d", step);
         e.d1 = m_regs[3]; e.p1 = m_pend[3]; e.d2 = m_regs[5]; e.p2 = m_pend[5];
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         vectors++;
         if (rd_data1 !== e.d1 || pend1 !== e.p1 || rd_data2 !== e.d2 || pend2 !== e.p2) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.tag, rd_data1, pend1,
                     rd_data2, pend2, e.d1, e.p1, e.d2, e.p2);
         end
      end
   endtask

   task automatic test_bypass();
      rd_exp_t e;
      @(posedge clk); #1;
      rsv_en = 1'b1; rsv_addr = 3'd2;
      @(posedge clk); #1;
      rsv_en = 1'b0; m_pend[2] = 1'b1;
      for (int step = 0; step < 2; step++) begin
         wr_en    = 1'b1; wr_addr = 3'd2;
         rsv_en   = (step == 1); rsv_addr = 3'd2;
         wr_data  = (step == 0) ? 16'hA5A5 : 16'h5A5A;
         rd_addr1 = 3'd2; rd_addr2 = (step == 0) ? 3'd3 : 3'd2;
         e.tag = $sformatf("bypass_same_cycle%0d", step);
         e.d1 = BYP ? wr_data : m_regs[2];
         e.p1 = BYP ? rsv_en : m_pend[2];
         e.d2 = (step == 0) ? m_regs[3] : e.d1;
         e.p2 = (step == 0) ? m_pend[3] : e.p1;
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         vectors++;
         if (rd_data1 !== e.d1 || pend1 !== e.p1 || rd_data2 !== e.d2 || pend2 !== e.p2) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.tag, rd_data1, pend1,
                     rd_data2, pend2, e.d1, e.p1, e.d2, e.p2);
         end
         @(posedge clk); #1;
         m_regs[2] = wr_data; m_pend[2] = rsv_en;
         wr_en = 1'b0; rsv_en = 1'b0;
         e.tag = $sformatf("bypass_next_cycle%0d", step);
         e.d1 = m_regs[2]; e.p1 = m_pend[2];
         e.d2 = (step == 0) ? m_regs[3] : m_regs[2];
         e.p2 = (step == 0) ? m_pend[3] : m_pend[2];
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         vectors++;
         if (rd_data1 !== e.d1 || pend1 !== e.p1 || rd_data2 !== e.d2 || pend2 !== e.p2) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.tag, rd_data1, pend1,
                     rd_data2, pend2, e.d1, e.p1, e.d2, e.p2);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_zero_reg();
      rd_exp_t e;
      rd_exp_t z;
      for (int k = 0; k < 4; k++) begin
         if (k == 0) begin
            wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
            rsv_en = 1'b1; rsv_addr = 3'd0;
         end
         rd_addr1 = 3'd0; rd_addr2 = 3'd0;
         e.tag = $sformatf("r0_plain_k%0d", k);
         e.d1 = (k == 0) ? (BYP ? 16'hFFFF : m_regs[0]) : 16'hFFFF;
         e.p1 = (k == 0) ? (BYP ? 1'b1 : m_pend[0]) : 1'b1;
         e.d2 = e.d1; e.p2 = e.p1;
         sb.push_back(e);
         z.tag = $sformatf("r0_zero_reg_k%0d", k);
         z.d1 = '0; z.p1 = 1'b0; z.d2 = '0; z.p2 = 1'b0;
         sb.push_back(z);
         @(negedge clk);
         e = sb.pop_front();
         vectors++;
         if (rd_data1 !== e.d1 || pend1 !== e.p1 || rd_data2 !== e.d2 || pend2 !== e.p2) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.tag, rd_data1, pend1,
                     rd_data2, pend2, e.d1, e.p1, e.d2, e.p2);
         end
         z = sb.pop_front();
         vectors++;
         if (z_rd_data1 !== z.d1 || z_pend1 !== z.p1 || z_rd_data2 !== z.d2 ||
             z_pend2 !== z.p2) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", z.tag, z_rd_data1, z_pend1,
                     z_rd_data2, z_pend2, z.d1, z.p1, z.d2, z.p2);
         end
         @(posedge clk); #1;
         if (k == 0) begin
            wr_en = 1'b0; rsv_en = 1'b0;
            m_regs[0] = 16'hFFFF; m_pend[0] = 1'b1;
         end
      end
   endtask

   task automatic test_clear();
      rd_exp_t  e;
      ctl_exp_t c;
      for (int i = 0; i < DEPTH; i++) begin
         wr_en = 1'b1; rsv_en = 1'b1;
         wr_addr = AW'(i); rsv_addr = AW'(i);
         wr_data = 16'h1000 + 16'(i) * 16'h0111;
         @(posedge clk); #1;
         m_regs[i] = wr_data; m_pend[i] = 1'b1;
      end
      wr_en = 1'b0; rsv_en = 1'b0;
      clr_req = 1'b1;
      rd_addr1 = 3'd0; rd_addr2 = 3'd7;
      for (int k = 0; k <= 10; k++) begin
         c.tag = $sformatf("sweep_ctl_k%0d", k);
         c.b = (k >= 1 && k <= 8);
         c.c = (k == 8);
         sbc.push_back(c);
         e.tag = $sformatf("sweep_read_k%0d", k);
         e.d1 = (k >= 2) ? '0 : m_regs[0]; e.p1 = (k >= 2) ? 1'b0 : m_pend[0];
         e.d2 = (k >= 9) ? '0 : m_regs[7]; e.p2 = (k >= 9) ? 1'b0 : m_pend[7];
         sb.push_back(e);
         @(negedge clk);
         c = sbc.pop_front();
         vectors++;
         if (busy !== c.b || clr_done !== c.c) begin
            errors++;
            $display("FAIL %s: busy=%b clr_done=%b want %b %b", c.tag, busy, clr_done, c.b, c.c);
         end
         e = sb.pop_front();
         vectors++;
         if (rd_data1 !== e.d1 || pend1 !== e.p1 || rd_data2 !== e.d2 || pend2 !== e.p2) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.tag, rd_data1, pend1,
                     rd_data2, pend2, e.d1, e.p1, e.d2, e.p2);
         end
         if (k == 1) begin
            clr_req = 1'b0;
            wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h7777;
            rsv_en = 1'b1; rsv_addr = 3'd6;
         end
         if (k == 8) begin
            wr_en = 1'b0; rsv_en = 1'b0;
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         rd_addr1 = AW'(i); rd_addr2 = AW'(DEPTH - 1 - i);
         e.tag = $sformatf("after_sweep_r%0d", i);
         e.d1 = m_regs[i]; e.p1 = m_pend[i];
         e.d2 = m_regs[DEPTH - 1 - i]; e.p2 = m_pend[DEPTH - 1 - i];
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         vectors++;
         if (rd_data1 !== e.d1 || pend1 !== e.p1 || rd_data2 !== e.d2 || pend2 !== e.p2) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.tag, rd_data1, pend1,
                     rd_data2, pend2, e.d1, e.p1, e.d2, e.p2);
         end
      end
   endtask

   task automatic test_back_to_back();
      ctl_exp_t c;
      @(posedge clk); #1;
      clr_req = 1'b1;
      for (int k = 0; k <= 18; k++) begin
         c.tag = $sformatf("b2b_ctl_k%0d", k);
         c.b = (k >= 1 && k <= 8) || (k >= 10 && k <= 17);
         c.c = (k == 8) || (k == 17);
         sbc.push_back(c);
         @(negedge clk);
         c = sbc.pop_front();
         vectors++;
         if (busy !== c.b || clr_done !== c.c) begin
            errors++;
            $display("FAIL %s: busy=%b clr_done=%b want %b %b", c.tag, busy, clr_done, c.b, c.c);
         end
         if (k == 10) clr_req = 1'b0;
      end
   endtask

   task automatic test_reset_mid_sweep();
      rd_exp_t  e;
      ctl_exp_t c;
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h5555;
      @(posedge clk); #1;
      wr_addr = 3'd7; wr_data = 16'h7007;
      @(posedge clk); #1;
      wr_en = 1'b0;
      clr_req = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) clr_req = 1'b0;
      end
      reset_n = 1'b0;
      #1;
      c.tag = "midsweep_reset_ctl"; c.b = 1'b0; c.c = 1'b0;
      sbc.push_back(c);
      c = sbc.pop_front();
      vectors++;
      if (busy !== c.b || clr_done !== c.c) begin
         errors++;
         $display("FAIL %s: busy=%b clr_done=%b want %b %b", c.tag, busy, clr_done, c.b, c.c);
      end
      for (int i = 0; i < DEPTH; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         rd_addr1 = AW'(i); rd_addr2 = AW'(i);
         e.tag = $sformatf("midsweep_reset_r%0d", i);
         e.d1 = m_regs[i]; e.p1 = m_pend[i]; e.d2 = m_regs[i]; e.p2 = m_pend[i];
         sb.push_back(e);
         #1;
         e = sb.pop_front();
         vectors++;
         if (rd_data1 !== e.d1 || pend1 !== e.p1 || rd_data2 !== e.d2 || pend2 !== e.p2) begin
            errors++;
            $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.tag, rd_data1, pend1,
                     rd_data2, pend2, e.d1, e.p1, e.d2, e.p2);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         c.tag = $sformatf("post_reset_ctl_k%0d", k); c.b = 1'b0; c.c = 1'b0;
         sbc.push_back(c);
         @(negedge clk);
         c = sbc.pop_front();
         vectors++;
         if (busy !== c.b || clr_done !== c.c) begin
            errors++;
            $display("FAIL %s: busy=%b clr_done=%b want %b %b", c.tag, busy, clr_done, c.b, c.c);
         end
      end
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444;
      @(posedge clk); #1;
      wr_en = 1'b0;
      m_regs[4] = 16'h4444;
      rd_addr1 = 3'd4; rd_addr2 = 3'd5;
      e.tag = "post_reset_write";
      e.d1 = m_regs[4]; e.p1 = m_pend[4]; e.d2 = m_regs[5]; e.p2 = m_pend[5];
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (rd_data1 !== e.d1 || pend1 !== e.p1 || rd_data2 !== e.d2 || pend2 !== e.p2) begin
         errors++;
         $display("FAIL %s: got %h/%b %h/%b want %h/%b %h/%b", e.tag, rd_data1, pend1,
                  rd_data2, pend2, e.d1, e.p1, e.d2, e.p2);
      end
   endtask

   initial begin
      rd_addr1 = '0; rd_addr2 = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rsv_en = 1'b0; rsv_addr = '0;
      clr_req = 1'b0;
      test_reset();
      test_write();
      test_scoreboard();
      test_bypass();
      test_zero_reg();
      test_clear();
      test_back_to_back();
      test_reset_mid_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-ported general-purpose register file with a per-register pending-write scoreboard and a sequenced clear engine. Sits in the processor datapath between decode and writeback. Supplies two operands per cycle, tracks in-flight destination registers so decode can stall on RAW hazards, and can be wiped under control without a global reset.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 0, when 1 register 0 always reads zero, ignores writes and is never marked pending

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_addr1  in  ADDR_W  read port 1 address
- rd_addr2  in  ADDR_W  read port 2 address
- rd_data1  out  DATA_W  read port 1 data, combinational
- rd_data2  out  DATA_W  read port 2 data, combinational
- pend1  out  1  scoreboard bit for rd_addr1, combinational
- pend2  out  1  scoreboard bit for rd_addr2, combinational
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback address
- wr_data  in  DATA_W  writeback data
- rsv_en  in  1  reserve strobe, marks rsv_addr pending
- rsv_addr  in  ADDR_W  register being issued as destination
- clr_req  in  1  start clear sweep, sampled in IDLE only
- busy  out  1  high while sweep runs
- clr_done  out  1  one-cycle pulse when sweep finishes

## Operation
- Storage: DEPTH x DATA_W flops plus DEPTH pending bits.
- Write: on a rising edge with wr_en=1 and busy=0, regs[wr_addr] <= wr_data and pend[wr_addr] <= 0.
- Reserve: on a rising edge with rsv_en=1 and busy=0, pend[rsv_addr] <= 1.
- Same edge, same address, wr_en and rsv_en both set: data is written and pend ends at 1. Reserve wins.
- Reads: rd_dataN = regs[rd_addrN]; pendN = pend[rd_addrN]. Both ports may use the same address.
- ZERO_REG=1: address 0 reads 0 with pend 0. Write and reserve to address 0 are dropped.
- FSM states:
  - IDLE -> CLEAR when clr_req=1. The counter loads 0.
  - CLEAR: each cycle zeroes regs[cnt] and pend[cnt], then cnt increments.
  - When cnt = DEPTH-1, the FSM returns to IDLE and clr_done pulses for exactly one cycle.
- Sweep length is exactly DEPTH cycles.
- During CLEAR:
  - wr_en and rsv_en are ignored and never queued. The upstream stage must hold them off using busy.
  - clr_req is ignored.
  - Reads return current contents, so they show a partially cleared file.
- Counter wraps cleanly: width ADDR_W, no overflow state.

## Timing
- Reset (reset_n=0, asynchronous):
  - all regs = 0, all pend = 0
  - FSM = IDLE, busy = 0, clr_done = 0
  - rd_data and pend outputs follow from that.
- Reset asserted mid-sweep aborts the sweep immediately. No clr_done is produced.
- Read latency is 0 (combinational). Write-to-read visibility is 1 cycle without bypass.
- busy rises on the edge after clr_req is sampled and stays high for DEPTH cycles. clr_done is coincident with the last busy cycle.
- Back-to-back sweeps: clr_req held high in the first IDLE cycle after a sweep starts a new sweep.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A same-cycle write forwards to the reads. If wr_en=1, busy=0 and wr_addr==rd_addrN (not the zero register when ZERO_REG=1), then rd_dataN = wr_data and pendN = rsv_en && rsv_addr==wr_addr.
  - This removes the writeback-to-decode bubble.
- REGFILE_BYPASS_EN undefined:
  - Reads show only committed state.
  - pendN stays 1 until the edge that performs the write.

## Test plan
- Reset then write: reset_n pulse, write 0xBEEF to r5, read r5 on both ports next cycle -> 0xBEEF on both, pend=0; all other registers read 0.
- Scoreboard: rsv r3, next cycle pend1(r3)=1; wr r3=0x1234 -> next cycle pend=0, data 0x1234. Simultaneous rsv+wr r3=0x0055 -> data 0x0055, pend=1.
- Bypass: wr r2=0xA5A5 with rd_addr1=2 in the same cycle.
  - With REGFILE_BYPASS_EN: rd_data1=0xA5A5 in that cycle.
  - Without it: old value in that cycle, 0xA5A5 next cycle.
- ZERO_REG=1: wr r0=0xFFFF and rsv r0 -> r0 reads 0 and pend 0 in all later cycles.
- Clear sweep (DEPTH=8):
  - Fill all registers with nonzero values and pend set. clr_req -> busy high 8 cycles, clr_done pulses on the 8th, afterwards all registers 0 and pend 0.
  - wr_en during busy leaves no effect.
- Reset mid-sweep: reset_n low at sweep cycle 4 -> busy=0 immediately, all registers 0, no clr_done. Normal write accepted after release.
